// File: rtl/pic_pkg.sv
// Shared definitions for the PIC priority controller: rotation modes and the
// one-hot to index helper used by the priority resolvers.
package pic_pkg;

   localparam int MAX_IRQ = 64;

   typedef enum logic [1:0] {
      ROT_FIXED    = 2'd0,
      ROT_AUTO     = 2'd1,
      ROT_SPECIFIC = 2'd2
   } rot_mode_t;

   // Callers zero-extend their one-hot vector to MAX_IRQ bits.
   function automatic int id_of(input logic [MAX_IRQ-1:0] oh);
      int id;
      id = 0;
      for (int i = 0; i < MAX_IRQ; i++) begin
         if (oh[i]) id = i;
      end
      return id;
   endfunction

endpackage

// File: rtl/pic_priority_ctrl_resolver.sv
// Rotating priority resolver: the channel after `lowest` is highest priority,
// priority descends with increasing index and wraps around.
module rot_priority_resolver
   import pic_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] req,
   input  logic [ID_W-1:0]    lowest,
   output logic [NUM_IRQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               any
);

   int                 start;
   logic [NUM_IRQ-1:0] rot_req;
   logic [NUM_IRQ-1:0] rot_grant;
   logic               found;

   // Rotate so the highest-priority channel lands on bit 0, pick the first
   // set bit, then rotate the grant back into channel order.
   always_comb begin
      start     = (int'(lowest) + 1 >= NUM_IRQ) ? 0 : int'(lowest) + 1;
      rot_req   = '0;
      rot_grant = '0;
      grant     = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         int idx;
         idx = i + start;
         if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
         rot_req[i] = req[idx];
      end
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (rot_req[i] && !found) begin
            rot_grant[i] = 1'b1;
            found        = 1'b1;
         end
      end
      for (int i = 0; i < NUM_IRQ; i++) begin
         int idx;
         idx = i + start;
         if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
         grant[idx] = rot_grant[i];
      end
   end

   assign any      = |req;
   assign grant_id = ID_W'(id_of(MAX_IRQ'(grant)));

endmodule

// File: rtl/pic_priority_ctrl.sv
// Interrupt priority controller: IRR/ISR/mask state, fixed or rotating
// priority, fully-nested int_out, acknowledge and EOI handling.
module pic_priority_ctrl
   import pic_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               level_mode,
   input  logic [NUM_IRQ-1:0] imr,
   input  logic [1:0]         rot_mode,
   input  logic               auto_eoi,
   input  logic               prio_wr,
   input  logic [ID_W-1:0]    prio_id,
   input  logic               ack,
   input  logic               eoi,
   input  logic               eoi_specific,
   input  logic [ID_W-1:0]    eoi_id,
   output logic               int_out,
   output logic               ack_valid,
   output logic [ID_W-1:0]    ack_id,
   output logic               ack_spurious,
   output logic [NUM_IRQ-1:0] irr,
   output logic [NUM_IRQ-1:0] isr
);

   localparam logic [NUM_IRQ-1:0] ONE = {{(NUM_IRQ-1){1'b0}}, 1'b1};

   logic [NUM_IRQ-1:0] irq_prev;
   logic [ID_W-1:0]    lowest;
   logic [ID_W-1:0]    lowest_next;
   logic [NUM_IRQ-1:0] higher, elig;
   logic [NUM_IRQ-1:0] req_grant, isr_grant;
   logic [ID_W-1:0]    req_id, isr_id;
   logic               req_any, isr_any;
   logic [NUM_IRQ-1:0] ack_set, ack_clr, eoi_clr;
   logic [NUM_IRQ-1:0] irr_next, isr_next;
   logic               ack_hit, eoi_id_ok, prio_id_ok;
   int                 start, isr_rank;
   rot_mode_t          mode;

   assign mode = rot_mode_t'(rot_mode);

   rot_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_req_res (
      .req(elig), .lowest(lowest), .grant(req_grant), .grant_id(req_id), .any(req_any)
   );

   rot_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_res (
      .req(isr), .lowest(lowest), .grant(isr_grant), .grant_id(isr_id), .any(isr_any)
   );

   // A request is eligible only if it outranks the top in-service channel.
   always_comb begin
      start    = (int'(lowest) + 1 >= NUM_IRQ) ? 0 : int'(lowest) + 1;
      isr_rank = int'(isr_id) - start;
      if (isr_rank < 0) isr_rank = isr_rank + NUM_IRQ;
      higher = '0;
      for (int ch = 0; ch < NUM_IRQ; ch++) begin
         int r;
         r = ch - start;
         if (r < 0) r = r + NUM_IRQ;
         higher[ch] = !isr_any || (r < isr_rank);
      end
      elig = irr & ~imr & higher;
   end

   assign int_out = req_any;

   always_comb begin
      ack_hit    = ack && req_any;
      ack_set    = (ack_hit && !auto_eoi) ? req_grant : '0;
      ack_clr    = (ack_hit && !level_mode) ? req_grant : '0;
      eoi_id_ok  = int'(eoi_id) < NUM_IRQ;
      prio_id_ok = int'(prio_id) < NUM_IRQ;
      eoi_clr    = '0;
      if (eoi) begin
         if (eoi_specific) begin
            if (eoi_id_ok) eoi_clr = ONE << eoi_id;
         end else begin
            eoi_clr = isr_grant;
         end
      end
      isr_next = (isr & ~eoi_clr) | ack_set;
      // A fresh rising edge wins over the ack clear of the same channel.
      irr_next = level_mode ? irq_in : ((irr & ~ack_clr) | (irq_in & ~irq_prev));
   end

   always_comb begin
      lowest_next = lowest;
      if (mode == ROT_AUTO) begin
         if (eoi && !eoi_specific && isr_any) lowest_next = isr_id;
         if (ack_hit && auto_eoi)             lowest_next = req_id;
      end else if (mode == ROT_SPECIFIC) begin
         if (eoi && eoi_specific && eoi_id_ok) lowest_next = eoi_id;
      end
      // Out-of-range writes are dropped so the rotation stays well-defined.
      if (prio_wr && prio_id_ok) lowest_next = prio_id;
   end

   // Ack handshake: ack is a one-cycle strobe with no back-pressure; the
   // response (ack_valid with ack_id/ack_spurious) is valid for exactly the
   // following cycle and carries no ready, so the consumer must take it then.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_prev     <= '0;
         irr          <= '0;
         isr          <= '0;
         lowest       <= ID_W'(NUM_IRQ - 1);
         ack_valid    <= 1'b0;
         ack_spurious <= 1'b0;
         ack_id       <= '0;
      end else begin
         irq_prev     <= irq_in;
         irr          <= irr_next;
         isr          <= isr_next;
         lowest       <= lowest_next;
         ack_valid    <= ack;
         ack_spurious <= ack && !req_any;
         if (ack) ack_id <= req_any ? req_id : ID_W'(NUM_IRQ - 1);
      end
   end

endmodule

// File: tb/tb_pic_priority_ctrl.sv
// Directed bench for pic_priority_ctrl with an 8-channel and a 5-channel instance.
module tb_pic_priority_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, level_mode, auto_eoi, prio_wr, ack, eoi, eoi_specific;
   logic [1:0] rot_mode;
   logic [7:0] irq_in, imr, irr, isr;
   logic [2:0] prio_id, eoi_id, ack_id;
   logic       int_out, ack_valid, ack_spurious;
   logic [4:0] irq5, imr5, irr5, isr5;
   logic [2:0] prio_id5, eoi_id5, ack_id5;
   logic       int_out5, ack_valid5, ack_spurious5;

   int checks   = 0;
   int failures = 0;

   pic_priority_ctrl #(.NUM_IRQ(8)) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .level_mode(level_mode), .imr(imr),
      .rot_mode(rot_mode), .auto_eoi(auto_eoi), .prio_wr(prio_wr), .prio_id(prio_id),
      .ack(ack), .eoi(eoi), .eoi_specific(eoi_specific), .eoi_id(eoi_id),
      .int_out(int_out), .ack_valid(ack_valid), .ack_id(ack_id),
      .ack_spurious(ack_spurious), .irr(irr), .isr(isr)
   );

   pic_priority_ctrl #(.NUM_IRQ(5)) dut5 (
      .clk(clk), .reset(reset), .irq_in(irq5), .level_mode(level_mode), .imr(imr5),
      .rot_mode(rot_mode), .auto_eoi(auto_eoi), .prio_wr(prio_wr), .prio_id(prio_id5),
      .ack(ack), .eoi(eoi), .eoi_specific(eoi_specific), .eoi_id(eoi_id5),
      .int_out(int_out5), .ack_valid(ack_valid5), .ack_id(ack_id5),
      .ack_spurious(ack_spurious5), .irr(irr5), .isr(isr5)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      irq_in = '0; irq5 = '0; imr = '0; imr5 = '0;
      level_mode = 1'b0; rot_mode = 2'd0; auto_eoi = 1'b0;
      prio_wr = 1'b0; prio_id = '0; prio_id5 = '0;
      ack = 1'b0; eoi = 1'b0; eoi_specific = 1'b0; eoi_id = '0; eoi_id5 = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (irr !== 8'h00) begin failures++; $display("FAIL reset_irr got=%h exp=00", irr); end
      checks++; if (isr !== 8'h00) begin failures++; $display("FAIL reset_isr got=%h exp=00", isr); end
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL reset_int got=%b exp=0", int_out); end
      checks++; if (ack_valid !== 1'b0) begin failures++; $display("FAIL reset_ack_valid got=%b exp=0", ack_valid); end
      checks++; if (ack_spurious !== 1'b0) begin failures++; $display("FAIL reset_spurious got=%b exp=0", ack_spurious); end
      checks++; if (ack_id !== 3'd0) begin failures++; $display("FAIL reset_ack_id got=%0d exp=0", ack_id); end
      checks++; if (dut.lowest !== 3'd7) begin failures++; $display("FAIL reset_lowest got=%0d exp=7", dut.lowest); end
      checks++; if (dut5.lowest !== 3'd4) begin failures++; $display("FAIL reset_lowest5 got=%0d exp=4", dut5.lowest); end
   endtask

   task automatic test_fixed_edge();
      apply_reset();
      irq_in = 8'h24;
      #1;
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL fixed_int_early got=%b exp=0", int_out); end
      tick();
      checks++; if (irr !== 8'h24) begin failures++; $display("FAIL fixed_irr got=%h exp=24", irr); end
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL fixed_int got=%b exp=1", int_out); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (ack_valid !== 1'b1) begin failures++; $display("FAIL fixed_ack_valid got=%b exp=1", ack_valid); end
      checks++; if (ack_id !== 3'd2) begin failures++; $display("FAIL fixed_ack_id got=%0d exp=2", ack_id); end
      checks++; if (ack_spurious !== 1'b0) begin failures++; $display("FAIL fixed_spurious got=%b exp=0", ack_spurious); end
      checks++; if (isr !== 8'h04) begin failures++; $display("FAIL fixed_isr got=%h exp=04", isr); end
      checks++; if (irr !== 8'h20) begin failures++; $display("FAIL fixed_irr_after got=%h exp=20", irr); end
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL fixed_int_blocked got=%b exp=0", int_out); end
      tick();
      checks++; if (ack_valid !== 1'b0) begin failures++; $display("FAIL fixed_ack_pulse got=%b exp=0", ack_valid); end
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL fixed_int_hold got=%b exp=0", int_out); end
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      checks++; if (isr !== 8'h00) begin failures++; $display("FAIL fixed_eoi_isr got=%h exp=00", isr); end
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL fixed_eoi_int got=%b exp=1", int_out); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (ack_id !== 3'd5) begin failures++; $display("FAIL fixed_ack2_id got=%0d exp=5", ack_id); end
      checks++; if (isr !== 8'h20) begin failures++; $display("FAIL fixed_ack2_isr got=%h exp=20", isr); end
   endtask

   task automatic test_nesting();
      apply_reset();
      irq_in = 8'h10;
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (isr !== 8'h10) begin failures++; $display("FAIL nest_isr got=%h exp=10", isr); end
      irq_in = 8'h50;
      tick();
      checks++; if (irr !== 8'h40) begin failures++; $display("FAIL nest_irr got=%h exp=40", irr); end
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL nest_low_int got=%b exp=0", int_out); end
      irq_in = 8'h52;
      tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL nest_high_int got=%b exp=1", int_out); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (ack_id !== 3'd1) begin failures++; $display("FAIL nest_ack_id got=%0d exp=1", ack_id); end
      checks++; if (isr !== 8'h12) begin failures++; $display("FAIL nest_isr2 got=%h exp=12", isr); end
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL nest_int_after got=%b exp=0", int_out); end
   endtask

   task automatic test_auto_rotate();
      apply_reset();
      rot_mode = 2'd1;
      irq_in = 8'h09;
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (ack_id !== 3'd0) begin failures++; $display("FAIL rot_ack0 got=%0d exp=0", ack_id); end
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      checks++; if (dut.lowest !== 3'd0) begin failures++; $display("FAIL rot_lowest got=%0d exp=0", dut.lowest); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (ack_id !== 3'd3) begin failures++; $display("FAIL rot_ack3 got=%0d exp=3", ack_id); end
      eoi = 1'b1; eoi_specific = 1'b1; eoi_id = 3'd3;
      tick();
      eoi = 1'b0; eoi_specific = 1'b0;
      checks++; if (dut.lowest !== 3'd0) begin failures++; $display("FAIL rot_specific_norot got=%0d exp=0", dut.lowest); end
      irq_in = 8'h08;
      tick();
      irq_in = 8'h89;
      tick();
      checks++; if (irr !== 8'h81) begin failures++; $display("FAIL rot_irr got=%h exp=81", irr); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (ack_id !== 3'd7) begin failures++; $display("FAIL rot_ack7 got=%0d exp=7", ack_id); end
   endtask

   task automatic test_auto_eoi();
      apply_reset();
      rot_mode = 2'd1; auto_eoi = 1'b1;
      irq_in = 8'h04;
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (ack_id !== 3'd2) begin failures++; $display("FAIL aeoi_ack_id got=%0d exp=2", ack_id); end
      checks++; if (isr !== 8'h00) begin failures++; $display("FAIL aeoi_isr got=%h exp=00", isr); end
      checks++; if (dut.lowest !== 3'd2) begin failures++; $display("FAIL aeoi_lowest got=%0d exp=2", dut.lowest); end
   endtask

   task automatic test_spurious();
      apply_reset();
      irq_in = 8'h01;
      tick();
      imr = 8'hFF;
      #1;
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL spur_masked_int got=%b exp=0", int_out); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (ack_valid !== 1'b1) begin failures++; $display("FAIL spur_valid got=%b exp=1", ack_valid); end
      checks++; if (ack_spurious !== 1'b1) begin failures++; $display("FAIL spur_flag got=%b exp=1", ack_spurious); end
      checks++; if (ack_id !== 3'd7) begin failures++; $display("FAIL spur_id got=%0d exp=7", ack_id); end
      checks++; if (isr !== 8'h00) begin failures++; $display("FAIL spur_isr got=%h exp=00", isr); end
      checks++; if (irr !== 8'h01) begin failures++; $display("FAIL spur_irr got=%h exp=01", irr); end
      imr = 8'h00;
      #1;
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL spur_unmask_int got=%b exp=1", int_out); end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      rot_mode = 2'd2;
      irq_in = 8'h20;
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      irq_in = 8'h24;
      tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL sim_int got=%b exp=1", int_out); end
      ack = 1'b1; eoi = 1'b1; eoi_specific = 1'b1; eoi_id = 3'd5; prio_wr = 1'b1; prio_id = 3'd3;
      tick();
      ack = 1'b0; eoi = 1'b0; eoi_specific = 1'b0; prio_wr = 1'b0;
      checks++; if (ack_id !== 3'd2) begin failures++; $display("FAIL sim_ack_id got=%0d exp=2", ack_id); end
      checks++; if (isr !== 8'h04) begin failures++; $display("FAIL sim_isr got=%h exp=04", isr); end
      checks++; if (dut.lowest !== 3'd3) begin failures++; $display("FAIL sim_lowest got=%0d exp=3", dut.lowest); end
      irq_in = 8'hA4;
      tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL sim_rotated_int got=%b exp=1", int_out); end
   endtask

   task automatic test_level_mode();
      apply_reset();
      level_mode = 1'b1;
      irq_in = 8'h08;
      tick();
      checks++; if (irr !== 8'h08) begin failures++; $display("FAIL lvl_irr got=%h exp=08", irr); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (isr !== 8'h08) begin failures++; $display("FAIL lvl_isr got=%h exp=08", isr); end
      checks++; if (irr !== 8'h08) begin failures++; $display("FAIL lvl_irr_kept got=%h exp=08", irr); end
      irq_in = 8'h00;
      tick();
      checks++; if (irr !== 8'h00) begin failures++; $display("FAIL lvl_irr_drop got=%h exp=00", irr); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      auto_eoi = 1'b1;
      irq_in = 8'h0C;
      tick();
      ack = 1'b1;
      tick();
      checks++; if (ack_id !== 3'd2) begin failures++; $display("FAIL b2b_first got=%0d exp=2", ack_id); end
      checks++; if (irr !== 8'h08) begin failures++; $display("FAIL b2b_irr got=%h exp=08", irr); end
      tick();
      ack = 1'b0;
      checks++; if (ack_id !== 3'd3) begin failures++; $display("FAIL b2b_second got=%0d exp=3", ack_id); end
      checks++; if (ack_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", ack_valid); end
      tick();
      checks++; if (ack_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", ack_valid); end
      checks++; if (irr !== 8'h00) begin failures++; $display("FAIL b2b_irr_end got=%h exp=00", irr); end
   endtask

   task automatic test_reset_mid_ack();
      apply_reset();
      irq_in = 8'h08;
      tick();
      ack = 1'b1;
      #2;
      reset = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (ack_valid !== 1'b0) begin failures++; $display("FAIL rst_ack_dropped got=%b exp=0", ack_valid); end
      irq_in = 8'h00;
      reset = 1'b0;
      tick();
      checks++; if (ack_valid !== 1'b0) begin failures++; $display("FAIL rst_ack_nopulse got=%b exp=0", ack_valid); end
      checks++; if (irr !== 8'h00) begin failures++; $display("FAIL rst_irr got=%h exp=00", irr); end
      checks++; if (isr !== 8'h00) begin failures++; $display("FAIL rst_isr got=%h exp=00", isr); end
      checks++; if (dut.lowest !== 3'd7) begin failures++; $display("FAIL rst_lowest got=%0d exp=7", dut.lowest); end
      irq_in = 8'h08;
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (ack_valid !== 1'b1) begin failures++; $display("FAIL rst2_valid got=%b exp=1", ack_valid); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (ack_valid !== 1'b0) begin failures++; $display("FAIL rst2_async got=%b exp=0", ack_valid); end
      checks++; if (isr !== 8'h00) begin failures++; $display("FAIL rst2_isr got=%h exp=00", isr); end
      reset = 1'b0;
   endtask

   task automatic test_n5_wrap();
      apply_reset();
      rot_mode = 2'd2;
      prio_wr = 1'b1; prio_id5 = 3'd2;
      tick();
      prio_wr = 1'b0;
      checks++; if (dut5.lowest !== 3'd2) begin failures++; $display("FAIL n5_lowest got=%0d exp=2", dut5.lowest); end
      irq5 = 5'h07;
      tick();
      checks++; if (int_out5 !== 1'b1) begin failures++; $display("FAIL n5_int got=%b exp=1", int_out5); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (ack_id5 !== 3'd0) begin failures++; $display("FAIL n5_wrap_id got=%0d exp=0", ack_id5); end
      checks++; if (isr5 !== 5'h01) begin failures++; $display("FAIL n5_isr got=%h exp=01", isr5); end
      checks++; if (int_out5 !== 1'b0) begin failures++; $display("FAIL n5_blocked got=%b exp=0", int_out5); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (ack_spurious5 !== 1'b1) begin failures++; $display("FAIL n5_spur got=%b exp=1", ack_spurious5); end
      checks++; if (ack_id5 !== 3'd4) begin failures++; $display("FAIL n5_spur_id got=%0d exp=4", ack_id5); end
      irq5 = 5'h17;
      tick();
      checks++; if (irr5 !== 5'h16) begin failures++; $display("FAIL n5_irr got=%h exp=16", irr5); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (ack_id5 !== 3'd4) begin failures++; $display("FAIL n5_ack4 got=%0d exp=4", ack_id5); end
      checks++; if (isr5 !== 5'h11) begin failures++; $display("FAIL n5_isr2 got=%h exp=11", isr5); end
      eoi = 1'b1; eoi_specific = 1'b1; eoi_id5 = 3'd7;
      tick();
      eoi_specific = 1'b0;
      checks++; if (isr5 !== 5'h11) begin failures++; $display("FAIL n5_badid_isr got=%h exp=11", isr5); end
      checks++; if (dut5.lowest !== 3'd2) begin failures++; $display("FAIL n5_badid_lowest got=%0d exp=2", dut5.lowest); end
      tick();
      eoi = 1'b0;
      checks++; if (isr5 !== 5'h01) begin failures++; $display("FAIL n5_nseoi got=%h exp=01", isr5); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fixed_edge();
      test_nesting();
      test_auto_rotate();
      test_auto_eoi();
      test_spurious();
      test_simultaneous();
      test_level_mode();
      test_back_to_back();
      test_reset_mid_ack();
      test_n5_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
